// File: rtl/cardinal_router_buf.sv
`default_nettype none
// =============================================================================
// cardinal_router_buf : five-port buffered XY mesh router node with per-input
// FIFOs, round-robin output arbitration and a saturating drop counter.
// Revision 1.0
// =============================================================================
module cardinal_router_buf #(
  parameter int DATA_W = 64,
  parameter int HOP_W  = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n_si,
  input  logic [DATA_W-1:0] n_di,
  output logic              n_ri,
  output logic              n_so,
  output logic [DATA_W-1:0] n_do,
  input  logic              n_ro,
  input  logic              s_si,
  input  logic [DATA_W-1:0] s_di,
  output logic              s_ri,
  output logic              s_so,
  output logic [DATA_W-1:0] s_do,
  input  logic              s_ro,
  input  logic              e_si,
  input  logic [DATA_W-1:0] e_di,
  output logic              e_ri,
  output logic              e_so,
  output logic [DATA_W-1:0] e_do,
  input  logic              e_ro,
  input  logic              w_si,
  input  logic [DATA_W-1:0] w_di,
  output logic              w_ri,
  output logic              w_so,
  output logic [DATA_W-1:0] w_do,
  input  logic              w_ro,
  input  logic              pe_si,
  input  logic [DATA_W-1:0] pe_di,
  output logic              pe_ri,
  output logic              pe_so,
  output logic [DATA_W-1:0] pe_do,
  input  logic              pe_ro,
  output logic              drop,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NP     = 5;
  localparam int AW     = $clog2(DEPTH);
  localparam int HX_LSB = DATA_W - 2 - HOP_W;
  localparam int HY_LSB = HX_LSB - HOP_W;

  localparam logic [2:0] P_N  = 3'd0;
  localparam logic [2:0] P_S  = 3'd1;
  localparam logic [2:0] P_E  = 3'd2;
  localparam logic [2:0] P_W  = 3'd3;
  localparam logic [2:0] P_PE = 3'd4;

  logic [NP-1:0]     si, ro, ri, so_q, full, empty, req, bad, dropv, grant, deq;
  logic [DATA_W-1:0] di     [NP];
  logic [DATA_W-1:0] do_q   [NP];
  logic [DATA_W-1:0] head   [NP];
  logic [DATA_W-1:0] fwd    [NP];
  logic [DATA_W-1:0] mem    [NP][DEPTH];
  logic [AW:0]       wr_ptr [NP];
  logic [AW:0]       rd_ptr [NP];
  logic [2:0]        dst    [NP];
  logic [2:0]        win    [NP];
  logic [2:0]        rr_ptr [NP];
  logic [HOP_W-1:0]  hx     [NP];
  logic [HOP_W-1:0]  hy     [NP];
  logic              arb_found;
  int                arb_idx;
  logic              drop_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        n_drop;
  logic [CNT_W+2:0]  cnt_sum;

  assign si = {pe_si, w_si, e_si, s_si, n_si};
  assign ro = {pe_ro, w_ro, e_ro, s_ro, n_ro};
  assign di[0] = n_di;
  assign di[1] = s_di;
  assign di[2] = e_di;
  assign di[3] = w_di;
  assign di[4] = pe_di;

  assign {pe_ri, w_ri, e_ri, s_ri, n_ri} = ri;
  assign {pe_so, w_so, e_so, s_so, n_so} = so_q;
  assign n_do     = do_q[0];
  assign s_do     = do_q[1];
  assign e_do     = do_q[2];
  assign w_do     = do_q[3];
  assign pe_do    = do_q[4];
  assign drop     = drop_q;
  assign drop_cnt = cnt_q;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      ri[i]    = reset & ~full[i];
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      hx[i]  = head[i][HX_LSB +: HOP_W];
      hy[i]  = head[i][HY_LSB +: HOP_W];
      fwd[i] = head[i];
      dst[i] = P_PE;
      if (hx[i] != '0) begin
        dst[i] = head[i][DATA_W-1] ? P_W : P_E;
        fwd[i][HX_LSB +: HOP_W] = hx[i] - 1'b1;
      end else if (hy[i] != '0) begin
        dst[i] = head[i][DATA_W-2] ? P_S : P_N;
        fwd[i][HY_LSB +: HOP_W] = hy[i] - 1'b1;
      end
      // U-turns and X hops still pending on a Y-axis arrival are discarded.
      bad[i]   = (dst[i] == 3'(i)) || ((i == 0 || i == 1) && hx[i] != '0);
      req[i]   = ~empty[i] & ~bad[i];
      dropv[i] = ~empty[i] & bad[i];
    end
  end

  always_comb begin
    grant     = '0;
    deq       = dropv;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int o = 0; o < NP; o++) begin
      win[o]    = P_N;
      arb_found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        arb_idx = int'(rr_ptr[o]) + k;
        if (arb_idx >= NP) arb_idx = arb_idx - NP;
        if (!arb_found && req[arb_idx] && dst[arb_idx] == 3'(o)) begin
          arb_found = 1'b1;
          win[o]    = 3'(arb_idx);
        end
      end
      grant[o] = arb_found & (~so_q[o] | ro[o]);
    end
    for (int o = 0; o < NP; o++) begin
      if (grant[o]) deq[win[o]] = 1'b1;
    end
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NP; i++) begin
      n_drop = n_drop + {2'b00, dropv[i]};
    end
    cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, n_drop};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (si[i] && ri[i]) mem[i][wr_ptr[i][AW-1:0]] <= di[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        so_q[i]   <= 1'b0;
        do_q[i]   <= '0;
        rr_ptr[i] <= P_N;
      end
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (si[i] && ri[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq[i])         rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (grant[i]) begin
          so_q[i]   <= 1'b1;
          do_q[i]   <= fwd[win[i]];
          rr_ptr[i] <= (win[i] == P_PE) ? P_N : win[i] + 3'd1;
        end else if (ro[i]) begin
          so_q[i]   <= 1'b0;
        end
      end
      drop_q <= |dropv;
      cnt_q  <= (cnt_sum > {3'b000, {CNT_W{1'b1}}}) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_router_buf.sv
`default_nettype none
// =============================================================================
// tb_cardinal_router_buf : directed and randomized scoreboard bench.
// Revision 1.0
// =============================================================================
module tb_cardinal_router_buf;

  localparam int DW = 64;

  typedef struct {
    int          src;
    int          dst;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  si, ro;
  logic [63:0] di [5];

  wire         n_ri, s_ri, e_ri, w_ri, pe_ri;
  wire         n_so, s_so, e_so, w_so, pe_so;
  wire [63:0]  n_do, s_do, e_do, w_do, pe_do;
  wire         drop;
  wire [15:0]  drop_cnt;

  logic [4:0]  ri, so;
  logic [63:0] dout [5];

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_drops = 0;

  always #5 clk = ~clk;

  assign ri = {pe_ri, w_ri, e_ri, s_ri, n_ri};
  assign so = {pe_so, w_so, e_so, s_so, n_so};
  assign dout[0] = n_do;
  assign dout[1] = s_do;
  assign dout[2] = e_do;
  assign dout[3] = w_do;
  assign dout[4] = pe_do;

  cardinal_router_buf #(.DATA_W(64), .HOP_W(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .n_si(si[0]),  .n_di(di[0]),  .n_ri(n_ri),  .n_so(n_so),  .n_do(n_do),  .n_ro(ro[0]),
    .s_si(si[1]),  .s_di(di[1]),  .s_ri(s_ri),  .s_so(s_so),  .s_do(s_do),  .s_ro(ro[1]),
    .e_si(si[2]),  .e_di(di[2]),  .e_ri(e_ri),  .e_so(e_so),  .e_do(e_do),  .e_ro(ro[2]),
    .w_si(si[3]),  .w_di(di[3]),  .w_ri(w_ri),  .w_so(w_so),  .w_do(w_do),  .w_ro(ro[3]),
    .pe_si(si[4]), .pe_di(di[4]), .pe_ri(pe_ri), .pe_so(pe_so), .pe_do(pe_do), .pe_ro(ro[4]),
    .drop(drop), .drop_cnt(drop_cnt)
  );

  function automatic logic [63:0] mk(input logic dx, input logic dy, input logic [3:0] hx,
                                     input logic [3:0] hy, input logic [53:0] pl);
    return {dx, dy, hx, hy, pl};
  endfunction

  // Reference routing: X hops first, then Y hops, then local delivery.
  function automatic void model_route(input int src, input logic [63:0] f, output int dst,
                                      output logic [63:0] fwd, output bit bad);
    int hx, hy;
    hx  = int'(f[61:58]);
    hy  = int'(f[57:54]);
    fwd = f;
    if (hx > 0) begin
      dst = f[63] ? 3 : 2;
      fwd[61:58] = 4'(hx - 1);
    end else if (hy > 0) begin
      dst = f[62] ? 1 : 0;
      fwd[57:54] = 4'(hy - 1);
    end else begin
      dst = 4;
    end
    bad = (dst == src) || (src < 2 && hx > 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Match an emitted flit against the oldest pending flit of each source.
  task automatic sb_match(input int o, input logic [63:0] d);
    bit seen [5];
    bit hit;
    hit = 1'b0;
    for (int s = 0; s < 5; s++) seen[s] = 1'b0;
    checks++;
    for (int j = 0; j < sbq.size(); j++) begin
      if (!hit && sbq[j].dst == o && !seen[sbq[j].src]) begin
        if (sbq[j].data === d) begin
          hit = 1'b1;
          sbq.delete(j);
          break;
        end
        seen[sbq[j].src] = 1'b1;
      end
    end
    if (!hit) begin
      errors++;
      $display("FAIL sb_out port %0d: got %h expected a pending head flit", o, d);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int o = 0; o < 5; o++) begin
        if (so[o] && ro[o]) sb_match(o, dout[o]);
      end
      for (int i = 0; i < 5; i++) begin
        if (si[i] && ri[i]) begin
          int          d;
          logic [63:0] f;
          bit          b;
          model_route(i, di[i], d, f, b);
          if (b) exp_drops++;
          else   sbq.push_back('{src: i, dst: d, data: f});
        end
      end
    end
  end

  int acc, nk, sk, ok, seen_so;

  initial begin
    reset = 1'b0;
    si    = '0;
    ro    = '1;
    for (int i = 0; i < 5; i++) di[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_so", 64'(so), 64'h0);
    chk("rst_ri", 64'(ri), 64'h0);
    chk("rst_drop", 64'(drop), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_e_do", e_do, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ri_after_release", 64'(ri), 64'h1f);

    // single east-bound flit from the PE
    @(posedge clk); #1;
    di[4] = mk(1'b0, 1'b0, 4'd2, 4'd0, 54'hABCD);
    si[4] = 1'b1;
    @(posedge clk); #1;
    si[4] = 1'b0;
    chk("t1_so_before_route", 64'(so), 64'h0);
    @(posedge clk); #1;
    chk("t1_only_e_so", 64'(so), 64'h04);
    chk("t1_e_do", e_do, mk(1'b0, 1'b0, 4'd1, 4'd0, 54'hABCD));

    // east output stalled: five flits stored, sixth refused
    repeat (2) @(posedge clk); #1;
    ro[2] = 1'b0;
    acc   = 0;
    si[4] = 1'b1;
    di[4] = mk(1'b0, 1'b0, 4'd1, 4'd0, 54'h100);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (si[4] && ri[4]) acc++;
      @(posedge clk); #1;
      if (acc < 6) di[4] = mk(1'b0, 1'b0, 4'd1, 4'd0, 54'h100 + 54'(acc));
    end
    chk("t2_accepted", 64'(acc), 64'd5);
    chk("t2_pe_ri_full", 64'(pe_ri), 64'h0);
    si[4] = 1'b0;
    ro[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_e_so_burst", 64'(e_so), 64'h1);
      chk("t2_e_do_order", e_do, mk(1'b0, 1'b0, 4'd0, 4'd0, 54'h100 + 54'(k)));
    end
    @(negedge clk);
    chk("t2_e_so_done", 64'(e_so), 64'h0);
    chk("t2_pe_ri_back", 64'(pe_ri), 64'h1);

    // N and S contend for the PE output
    @(posedge clk); #1;
    nk = 0; sk = 0; ok = 0;
    si[0] = 1'b1; di[0] = mk(1'b0, 1'b0, 4'd0, 4'd0, 54'h1000);
    si[1] = 1'b1; di[1] = mk(1'b0, 1'b0, 4'd0, 4'd0, 54'h2000);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (si[0] && ri[0]) nk++;
      if (si[1] && ri[1]) sk++;
      if (pe_so && ok < 8) begin
        chk("t3_pe_alternate", pe_do, mk(1'b0, 1'b0, 4'd0, 4'd0,
            (ok % 2 == 1 ? 54'h2000 : 54'h1000) + 54'(ok / 2)));
        ok++;
      end else if (ok > 0 && ok < 8) begin
        chk("t3_pe_so_gap", 64'(pe_so), 64'h1);
      end
      @(posedge clk); #1;
      if (nk < 8) di[0] = mk(1'b0, 1'b0, 4'd0, 4'd0, 54'h1000 + 54'(nk));
      else        si[0] = 1'b0;
      if (sk < 8) di[1] = mk(1'b0, 1'b0, 4'd0, 4'd0, 54'h2000 + 54'(sk));
      else        si[1] = 1'b0;
    end
    chk("t3_pe_outputs", 64'(ok), 64'd8);

    // U-turn drop, then XY-violation drop
    @(posedge clk); #1;
    di[2] = mk(1'b0, 1'b0, 4'd1, 4'd0, 54'h55);
    si[2] = 1'b1;
    @(posedge clk); #1;
    si[2] = 1'b0;
    chk("t4_drop_early", 64'(drop), 64'h0);
    @(posedge clk); #1;
    chk("t4_drop_pulse", 64'(drop), 64'h1);
    chk("t4_drop_cnt1", 64'(drop_cnt), 64'd1);
    chk("t4_no_so", 64'(so), 64'h0);
    @(posedge clk); #1;
    chk("t4_drop_one_cycle", 64'(drop), 64'h0);
    di[0] = mk(1'b0, 1'b0, 4'd3, 4'd0, 54'h66);
    si[0] = 1'b1;
    @(posedge clk); #1;
    si[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t4_drop_cnt2", 64'(drop_cnt), 64'd2);

    // reset with flits buffered behind stalled outputs
    ro    = '0;
    di[4] = mk(1'b0, 1'b0, 4'd1, 4'd0, 54'h77);
    si[4] = 1'b1;
    repeat (3) @(posedge clk);
    #1 si[4] = 1'b0;
    @(posedge clk); #1;
    chk("t5_buffered", 64'(so), 64'h04);
    #3;
    reset = 1'b0;
    sbq.delete();
    exp_drops = 0;
    #1;
    chk("t5_so_cleared", 64'(so), 64'h0);
    chk("t5_cnt_cleared", 64'(drop_cnt), 64'h0);
    chk("t5_ri_in_reset", 64'(ri), 64'h0);
    #3 reset = 1'b1;
    #1 chk("t5_ri_released", 64'(ri), 64'h1f);
    ro = '1;
    seen_so = 0;
    repeat (10) begin
      @(negedge clk);
      if (so != '0) seen_so++;
    end
    chk("t5_no_ghost_flit", 64'(seen_so), 64'h0);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        si[i] = ($urandom_range(0, 1) == 1);
        di[i] = mk(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 54'({$urandom, $urandom}));
        ro[i] = ($urandom_range(0, 9) < 7);
      end
    end
    @(posedge clk); #1;
    si = '0;
    ro = '1;
    repeat (40) @(posedge clk);
    #1;
    chk("rand_sb_drained", 64'(sbq.size()), 64'h0);
    chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    chk("rand_idle_so", 64'(so), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
